// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage of the 5-stage pipeline.
// Holds the PC and selects the next PC (jr > jump > branch > sequential).
// Drives the IF/ID enable and flush controls.
// Keeps a sticky misalignment flag and saturating fetch/stall counters.
module pc_fetch_unit #(
  parameter int            N        = 32,
  parameter logic [N-1:0]  RESET_PC = N'(32'h0040_0000),
  parameter int            CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [N-1:0]     branch_target_i,
  input  logic             jump_i,
  input  logic [N-1:0]     jump_target_i,
  input  logic             jr_i,
  input  logic [N-1:0]     jr_target_i,
  output logic [N-1:0]     pc_o,
  output logic [N-1:0]     pc4_o,
  output logic             if_id_enable_o,
  output logic             if_id_flush_o,
  output logic             align_err_o,
  output logic [CNT_W-1:0] fetch_count_o,
  output logic [CNT_W-1:0] stall_count_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic [N-1:0]     r_pc;
  logic [N-1:0]     w_pc_next;
  logic [N-1:0]     w_pc4;
  logic [N-1:0]     w_target;
  logic             w_redirect;
  logic             w_advance;
  logic             w_stall_cnt;
  logic             w_misaligned;
  logic             r_align_err;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Sequential successor wraps modulo 2^N.
  assign w_pc4 = r_pc + N'(4);

  // Next-state, next-PC and IF/ID control decode.
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_target       = w_pc4;
    w_redirect     = 1'b0;
    w_advance      = 1'b0;
    w_stall_cnt    = 1'b0;
    w_misaligned   = 1'b0;
    if_id_enable_o = 1'b0;
    if_id_flush_o  = 1'b0;
    case (r_state)
      ST_BOOT: begin
        // First cycle out of reset: hold PC, keep IF/ID flushed.
        if_id_flush_o = 1'b1;
        w_state_next  = ST_RUN;
      end
      ST_RUN, ST_HOLD: begin
        if (stall_i) begin
          // Redirects stay pending in ID and re-present after the stall.
          w_stall_cnt  = 1'b1;
          w_state_next = ST_HOLD;
        end else begin
          if_id_enable_o = 1'b1;
          w_advance      = 1'b1;
          w_state_next   = ST_RUN;
          if (jr_i) begin
            w_target   = jr_target_i;
            w_redirect = 1'b1;
          end else if (jump_i) begin
            w_target   = jump_target_i;
            w_redirect = 1'b1;
          end else if (branch_taken_i) begin
            w_target   = branch_target_i;
            w_redirect = 1'b1;
          end
          if (w_redirect) begin
            // Kill the wrong-path instruction currently in IF.
            if_id_flush_o = 1'b1;
            w_misaligned  = (w_target[1:0] != 2'b00);
            w_pc_next     = {w_target[N-1:2], 2'b00};
          end else begin
            w_pc_next = w_pc4;
          end
        end
      end
      default: begin
        if_id_flush_o = 1'b1;
        w_state_next  = ST_BOOT;
      end
    endcase
  end

  // State, PC, sticky alignment flag and saturating counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_align_err <= 1'b0;
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_misaligned) begin
        r_align_err <= 1'b1;
      end
      if (w_advance && (r_fetch_cnt != CNT_MAX)) begin
        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
      end
      if (w_stall_cnt && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_o          = r_pc;
  assign pc4_o         = w_pc4;
  assign align_err_o   = r_align_err;
  assign fetch_count_o = r_fetch_cnt;
  assign stall_count_o = r_stall_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios followed by random traffic.
// Each cycle's expected outputs go into a queue, and a monitor checks them.
// A second instance with 2-bit counters exercises counter saturation.
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        en;
    logic        flush;
    logic        align;
    logic [15:0] fc;
    logic [15:0] sc;
    logic [1:0]  fc2;
    logic [1:0]  sc2;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_target_i = '0;
  logic        jr_i = 1'b0;
  logic [31:0] jr_target_i = '0;

  logic [31:0] pc_o, pc4_o, pc_o_b, pc4_o_b;
  logic        en_o, flush_o, align_o, en_o_b, flush_o_b, align_o_b;
  logic [15:0] fc_o, sc_o;
  logic [1:0]  fc_o_b, sc_o_b;

  int total = 0;
  int bad = 0;
  int txn = 0;
  exp_t exp_q[$];

  // Behavioural model state.
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_align;
  int          m_fc, m_sc;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall_i(stall_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .jr_i(jr_i), .jr_target_i(jr_target_i),
    .pc_o(pc_o), .pc4_o(pc4_o), .if_id_enable_o(en_o), .if_id_flush_o(flush_o),
    .align_err_o(align_o), .fetch_count_o(fc_o), .stall_count_o(sc_o)
  );

  pc_fetch_unit #(.N(32), .RESET_PC(32'h0040_0000), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .stall_i(stall_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_target_i(jump_target_i),
    .jr_i(jr_i), .jr_target_i(jr_target_i),
    .pc_o(pc_o_b), .pc4_o(pc4_o_b), .if_id_enable_o(en_o_b), .if_id_flush_o(flush_o_b),
    .align_err_o(align_o_b), .fetch_count_o(fc_o_b), .stall_count_o(sc_o_b)
  );

  function automatic int sat(input int v, input int maxv);
    return (v >= maxv) ? maxv : v;
  endfunction

  // One cycle of stimulus: drive, record expected outputs, then advance the model.
  task automatic step(input bit rst_n, input bit st,
                      input bit br, input logic [31:0] bt,
                      input bit j,  input logic [31:0] jt,
                      input bit jr, input logic [31:0] jrt);
    exp_t e;
    bit redirect;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    reset = rst_n; stall_i = st;
    branch_taken_i = br; branch_target_i = bt;
    jump_i = j; jump_target_i = jt;
    jr_i = jr; jr_target_i = jrt;
    if (!rst_n) begin
      m_pc = 32'h0040_0000; m_boot = 1; m_align = 0; m_fc = 0; m_sc = 0;
    end
    redirect = jr | j | br;
    e.pc    = m_pc;
    e.pc4   = m_pc + 32'd4;
    e.en    = !m_boot && !st;
    e.flush = m_boot || (!st && redirect);
    e.align = m_align;
    e.fc    = 16'(sat(m_fc, 65535));
    e.sc    = 16'(sat(m_sc, 65535));
    e.fc2   = 2'(sat(m_fc, 3));
    e.sc2   = 2'(sat(m_sc, 3));
    exp_q.push_back(e);
    if (rst_n) begin
      if (m_boot) begin
        m_boot = 0;
      end else if (st) begin
        m_sc++;
      end else begin
        m_fc++;
        if (redirect) begin
          tgt = jr ? jrt : (j ? jt : bt);
          if (tgt % 4 != 0) m_align = 1;
          m_pc = tgt - (tgt % 4);
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents outputs; compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a.pc = pc_o; a.pc4 = pc4_o; a.en = en_o; a.flush = flush_o; a.align = align_o;
      a.fc = fc_o; a.sc = sc_o; a.fc2 = fc_o_b; a.sc2 = sc_o_b;
      total++;
      txn++;
      if (a !== e || pc_o_b !== e.pc || flush_o_b !== e.flush || en_o_b !== e.en) begin
        bad++;
        $display("FAIL txn%0d outputs: got pc=%h pc4=%h en=%b fl=%b al=%b fc=%0d sc=%0d fc2=%0d sc2=%0d | want pc=%h pc4=%h en=%b fl=%b al=%b fc=%0d sc=%0d fc2=%0d sc2=%0d",
                 txn, a.pc, a.pc4, a.en, a.flush, a.align, a.fc, a.sc, a.fc2, a.sc2,
                 e.pc, e.pc4, e.en, e.flush, e.align, e.fc, e.sc, e.fc2, e.sc2);
      end else begin
        $display("txn%0d ok pc=%h en=%b fl=%b al=%b fc=%0d sc=%0d", txn, a.pc, a.en, a.flush, a.align, a.fc, a.sc);
      end
    end
  end

  initial begin
    m_pc = 32'h0040_0000; m_boot = 1; m_align = 0; m_fc = 0; m_sc = 0;
    // Reset, then free run (boot cycle plus sequential fetch).
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    run(6);
    // Two stall cycles, then resume.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    run(2);
    // All three redirects at once: jr wins.
    step(1, 0, 1, 32'h0040_0300, 1, 32'h0040_0200, 1, 32'h0040_0100);
    run(2);
    // Branch while stalled is ignored, then taken once the stall clears.
    step(1, 1, 1, 32'h0040_0800, 0, 0, 0, 0);
    step(1, 0, 1, 32'h0040_0800, 0, 0, 0, 0);
    run(2);
    // Misaligned jump target sets the sticky flag.
    step(1, 0, 0, 0, 1, 32'h0040_0102, 0, 0);
    run(3);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    run(2);
    // PC wraps past the top of the address space.
    step(1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFF8);
    run(4);
    // Random traffic with occasional mid-operation reset.
    for (int i = 0; i < 600; i++) begin
      bit rst_n, st, br, j, jr;
      logic [31:0] bt, jt, jrt;
      rst_n = ($urandom_range(0, 99) >= 2);
      st  = ($urandom_range(0, 99) < 30);
      br  = ($urandom_range(0, 99) < 15);
      j   = ($urandom_range(0, 99) < 10);
      jr  = ($urandom_range(0, 99) < 8);
      bt  = $urandom(); jt = $urandom(); jrt = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        bt[1:0] = 2'b00; jt[1:0] = 2'b00; jrt[1:0] = 2'b00;
      end
      step(rst_n, st, br, bt, j, jt, jr, jrt);
    end
    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got pending=%0d want pending=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
